sine_fetch_scheduler: RTL and testbench

//  Shares one synchronous sine ROM and one ROM_management serializer between two sine channels (A, B).

---
 rtl/sine_fetch_scheduler_pkg.sv | 34 +++
 rtl/sine_fetch_scheduler_rate_divider.sv | 37 +++
 rtl/sine_fetch_scheduler.sv | 121 ++++++++++++
 tb/tb_sine_fetch_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sine_fetch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sine_fetch_scheduler_pkg
// Brief    : Shared widths, FSM encodings and arbitration helper for the
//            two-channel sine ROM fetch scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sine_fetch_scheduler_pkg;

   localparam int c_def_addr_w  = 8;
   localparam int c_def_data_w  = 32;
   localparam int c_def_phase_w = 16;
   localparam int c_def_div_w   = 16;

   typedef logic [1:0] state_t;

   localparam state_t c_st_idle  = 2'd0;
   localparam state_t c_st_read  = 2'd1;
   localparam state_t c_st_latch = 2'd2;
   localparam state_t c_st_send  = 2'd3;

   localparam logic c_ch_a = 1'b0;
   localparam logic c_ch_b = 1'b1;

   // Round-robin pick: on a tie the channel that did not win last time goes.
   function automatic logic pick_grant(input logic pend_a, input logic pend_b,
                                       input logic last_grant);
      if (pend_a && pend_b)
         return ~last_grant;
      return pend_b ? c_ch_b : c_ch_a;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sine_fetch_scheduler_rate_divider.sv
`default_nettype none
// ============================================================================
// Module   : sine_fetch_scheduler_rate_divider
// Brief    : Sample-period divider; pulses expire once every div clocks.
// Revision : 1.0 - initial release
// ============================================================================
module sine_fetch_scheduler_rate_divider
   import sine_fetch_scheduler_pkg::*;
#(
   parameter int DIV_W = c_def_div_w
) (
   input  logic             clk,
   input  logic             RST_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             expire
);

   logic [DIV_W-1:0] r_cnt;
   logic             w_run;

   // Counts elapsed clocks upward; clearing to 0 is the same as reloading a
   // down-counter with div-1, and >= copes with div shrinking mid-period.
   assign w_run  = en && (div != '0);
   assign expire = w_run && (r_cnt >= (div - DIV_W'(1)));

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)
         r_cnt <= '0;
      else if (!w_run || expire)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + DIV_W'(1);
   end

endmodule
`default_nettype wire

// File: rtl/sine_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sine_fetch_scheduler
// Brief    : Round-robin fetch of sine ROM words for channels A/B, handed to
//            the serializer with a one-clock tick.
// Revision : 1.0 - initial release
// ============================================================================
module sine_fetch_scheduler
   import sine_fetch_scheduler_pkg::*;
#(
   parameter int ADDR_W  = c_def_addr_w,
   parameter int DATA_W  = c_def_data_w,
   parameter int PHASE_W = c_def_phase_w,
   parameter int DIV_W   = c_def_div_w
) (
   input  logic               clk,
   input  logic               RST_n,
   input  logic               en,
   input  logic [DIV_W-1:0]   div_a,
   input  logic [DIV_W-1:0]   div_b,
   input  logic [PHASE_W-1:0] inc_a,
   input  logic [PHASE_W-1:0] inc_b,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [DATA_W-1:0]  rom_data,
   output logic [DATA_W-1:0]  ser_data,
   output logic               ser_tick,
   input  logic               ser_busy,
   output logic               ch_sel,
   output logic [1:0]         overrun
);

   state_t             r_state, w_state_next;
   logic [PHASE_W-1:0] r_phase_a, r_phase_b, w_phase_g;
   logic               r_pend_a, r_pend_b, r_last, r_ch, r_tick;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_data;
   logic [1:0]         r_overrun;
   logic               w_exp_a, w_exp_b;
   logic               w_grant, w_grant_ch, w_take_a, w_take_b;
   logic               w_tick_next, w_latch;

   sine_fetch_scheduler_rate_divider #(.DIV_W(DIV_W)) u_div_a (
      .clk(clk), .RST_n(RST_n), .en(en), .div(div_a), .expire(w_exp_a)
   );

   sine_fetch_scheduler_rate_divider #(.DIV_W(DIV_W)) u_div_b (
      .clk(clk), .RST_n(RST_n), .en(en), .div(div_b), .expire(w_exp_b)
   );

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)
         r_state <= c_st_idle;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle:  if (w_grant) w_state_next = c_st_read;
         c_st_read:  w_state_next = c_st_latch;
         c_st_latch: w_state_next = c_st_send;
         c_st_send:  if (r_tick) w_state_next = c_st_idle;
         default:    w_state_next = c_st_idle;
      endcase
   end

   // The tick is registered so it lines up with ser_data in the SEND cycle;
   // while parked in SEND it fires one clock after busy is seen low.
   always_comb begin
      w_grant     = (r_state == c_st_idle) && en && (r_pend_a || r_pend_b);
      w_grant_ch  = pick_grant(r_pend_a, r_pend_b, r_last);
      w_take_a    = w_grant && (w_grant_ch == c_ch_a);
      w_take_b    = w_grant && (w_grant_ch == c_ch_b);
      w_phase_g   = (w_grant_ch == c_ch_b) ? r_phase_b : r_phase_a;
      w_latch     = (r_state == c_st_latch);
      w_tick_next = !ser_busy &&
                    ((r_state == c_st_latch) || ((r_state == c_st_send) && !r_tick));
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         r_phase_a <= '0;
         r_phase_b <= '0;
         r_pend_a  <= 1'b0;
         r_pend_b  <= 1'b0;
         r_last    <= c_ch_b;
         r_ch      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_tick    <= 1'b0;
         r_overrun <= '0;
      end else begin
         r_tick <= w_tick_next;
         if (w_latch)
            r_data <= rom_data;
         if (w_grant) begin
            r_addr <= w_phase_g[PHASE_W-1 -: ADDR_W];
            r_ch   <= w_grant_ch;
            r_last <= w_grant_ch;
         end
         if (w_take_a)
            r_phase_a <= r_phase_a + inc_a;
         if (w_take_b)
            r_phase_b <= r_phase_b + inc_b;
         // A fresh expiry in the channel's own grant cycle re-arms it instead of counting as lost.
         r_pend_a     <= en && (w_take_a ? w_exp_a : (r_pend_a || w_exp_a));
         r_pend_b     <= en && (w_take_b ? w_exp_b : (r_pend_b || w_exp_b));
         r_overrun[0] <= r_overrun[0] || (w_exp_a && r_pend_a && !w_take_a);
         r_overrun[1] <= r_overrun[1] || (w_exp_b && r_pend_b && !w_take_b);
      end
   end

   assign rom_addr = r_addr;
   assign ser_data = r_data;
   assign ser_tick = r_tick;
   assign ch_sel   = r_ch;
   assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sine_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sine_fetch_scheduler
// Brief    : Directed, table-driven bench for sine_fetch_scheduler with a
//            synchronous ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sine_fetch_scheduler;

   logic        clk;
   logic        RST_n;
   logic        en;
   logic [15:0] div_a, div_b, inc_a, inc_b;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] ser_data;
   logic        ser_tick;
   logic        ser_busy;
   logic        ch_sel;
   logic [1:0]  overrun;

   int n_tests;
   int n_fail;

   typedef struct {
      bit          first;
      logic [15:0] div_a, div_b, inc_a, inc_b;
      logic        ch;
      logic [7:0]  addr;
      int          gap;
      logic [1:0]  ov;
   } vec_t;

   vec_t vecs[$];

   sine_fetch_scheduler dut (
      .clk(clk), .RST_n(RST_n), .en(en),
      .div_a(div_a), .div_b(div_b), .inc_a(inc_a), .inc_b(inc_b),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .ser_data(ser_data), .ser_tick(ser_tick), .ser_busy(ser_busy),
      .ch_sel(ch_sel), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [7:0] a);
      return {a, ~a, a ^ 8'hA5, a + 8'h3C};
   endfunction

   always_ff @(posedge clk) rom_data <= rom_word(rom_addr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input bit first, input logic [15:0] da, input logic [15:0] db,
                      input logic [15:0] ia, input logic [15:0] ib, input logic ch,
                      input logic [7:0] addr, input int gap, input logic [1:0] ov);
      vec_t v;
      v.first = first; v.div_a = da; v.div_b = db; v.inc_a = ia; v.inc_b = ib;
      v.ch = ch; v.addr = addr; v.gap = gap; v.ov = ov;
      vecs.push_back(v);
   endtask

   // Reset with the given config applied; released on a negedge so the next posedge is clock 1.
   task automatic do_reset(input logic [15:0] da, input logic [15:0] db,
                           input logic [15:0] ia, input logic [15:0] ib, input logic busy);
      RST_n    = 1'b0;
      en       = 1'b1;
      div_a    = da;  div_b = db;
      inc_a    = ia;  inc_b = ib;
      ser_busy = busy;
      repeat (3) @(negedge clk);
      RST_n = 1'b1;
   endtask

   task automatic wait_tick(input int start, output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = start;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (ser_tick) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int  cyc, base, ticks;
      bit  ok;
      n_tests = 0;
      n_fail  = 0;

      //    first da      db      ia        ib        ch addr   gap ov
      add(1, 16'd5,  16'd0,  16'h0100, 16'h0000, 0, 8'h00, 8,  2'b00);
      add(1, 16'd8,  16'd0,  16'h0100, 16'h0000, 0, 8'h00, 11, 2'b00);
      add(0, 16'd8,  16'd0,  16'h0100, 16'h0000, 0, 8'h01, 8,  2'b00);
      add(0, 16'd8,  16'd0,  16'h0100, 16'h0000, 0, 8'h02, 8,  2'b00);
      add(0, 16'd8,  16'd0,  16'h0100, 16'h0000, 0, 8'h03, 8,  2'b00);
      add(1, 16'd10, 16'd10, 16'h0100, 16'h0100, 0, 8'h00, 13, 2'b00);
      add(0, 16'd10, 16'd10, 16'h0100, 16'h0100, 1, 8'h00, 4,  2'b00);
      add(0, 16'd10, 16'd10, 16'h0100, 16'h0100, 0, 8'h01, 6,  2'b00);
      add(0, 16'd10, 16'd10, 16'h0100, 16'h0100, 1, 8'h01, 4,  2'b00);
      add(1, 16'd4,  16'd0,  16'hC000, 16'h0000, 0, 8'h00, 7,  2'b00);
      add(0, 16'd4,  16'd0,  16'hC000, 16'h0000, 0, 8'hC0, 4,  2'b00);
      add(0, 16'd4,  16'd0,  16'hC000, 16'h0000, 0, 8'h80, 4,  2'b00);
      add(0, 16'd4,  16'd0,  16'hC000, 16'h0000, 0, 8'h40, 4,  2'b00);
      add(0, 16'd4,  16'd0,  16'hC000, 16'h0000, 0, 8'h00, 4,  2'b00);
      // div=3: expiry lands in A's own grant cycle at clock 11 (no overrun), true loss at 14
      add(1, 16'd3,  16'd0,  16'h0100, 16'h0000, 0, 8'h00, 6,  2'b00);
      add(0, 16'd3,  16'd0,  16'h0100, 16'h0000, 0, 8'h01, 4,  2'b00);
      add(0, 16'd3,  16'd0,  16'h0100, 16'h0000, 0, 8'h02, 4,  2'b00);
      add(0, 16'd3,  16'd0,  16'h0100, 16'h0000, 0, 8'h03, 4,  2'b01);
      add(1, 16'd1,  16'd0,  16'h0100, 16'h0000, 0, 8'h00, 4,  2'b01);
      add(0, 16'd1,  16'd0,  16'h0100, 16'h0000, 0, 8'h01, 4,  2'b01);
      add(1, 16'd0,  16'd6,  16'h0000, 16'h0300, 1, 8'h00, 9,  2'b00);
      add(0, 16'd0,  16'd6,  16'h0000, 16'h0300, 1, 8'h03, 6,  2'b00);

      // Reset state held with a live configuration
      RST_n = 1'b0; en = 1'b1; div_a = 16'd5; div_b = 16'd0;
      inc_a = 16'h0100; inc_b = 16'h0000; ser_busy = 1'b0;
      ticks = 0;
      repeat (4) begin
         @(negedge clk);
         if (ser_tick) ticks++;
      end
      check("rst_tick", 64'(ticks), 64'd0);
      check("rst_addr", 64'(rom_addr), 64'd0);
      check("rst_data", 64'(ser_data), 64'd0);
      check("rst_ch", 64'(ch_sel), 64'd0);
      check("rst_ovr", 64'(overrun), 64'd0);

      base = 0;
      foreach (vecs[i]) begin
         if (vecs[i].first) begin
            do_reset(vecs[i].div_a, vecs[i].div_b, vecs[i].inc_a, vecs[i].inc_b, 1'b0);
            base = 0;
         end
         wait_tick(base, cyc, ok);
         check($sformatf("v%0d_tick_seen", i), 64'(ok), 64'd1);
         if (ok) begin
            check($sformatf("v%0d_gap", i), 64'(cyc), 64'(vecs[i].gap));
            check($sformatf("v%0d_ch", i), 64'(ch_sel), 64'(vecs[i].ch));
            check($sformatf("v%0d_addr", i), 64'(rom_addr), 64'(vecs[i].addr));
            check($sformatf("v%0d_data", i), 64'(ser_data), 64'(rom_word(vecs[i].addr)));
            check($sformatf("v%0d_ovr", i), 64'(overrun), 64'(vecs[i].ov));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_tick_width", i), 64'(ser_tick), 64'd0);
            base = 1;
         end
      end

      // Backpressure: parked in SEND, A keeps expiring every 4 clocks
      do_reset(16'd4, 16'd0, 16'h0100, 16'h0000, 1'b1);
      ticks = 0;
      repeat (30) begin
         @(posedge clk);
         @(negedge clk);
         if (ser_tick) ticks++;
      end
      check("bp_no_tick", 64'(ticks), 64'd0);
      check("bp_ovr", 64'(overrun), 64'd1);
      ser_busy = 1'b0;
      ticks = 0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         if (ser_tick) ticks++;
      end
      check("bp_one_tick", 64'(ticks), 64'd1);
      check("bp_ovr_sticky", 64'(overrun), 64'd1);
      check("bp_next_addr", 64'(rom_addr), 64'd1);
      check("bp_data_hold", 64'(ser_data), 64'(rom_word(8'h00)));

      // Asynchronous reset while parked in SEND
      do_reset(16'd4, 16'd0, 16'h0100, 16'h0000, 1'b1);
      repeat (14) @(negedge clk);
      check("mr_pre_ovr", 64'(overrun), 64'd1);
      check("mr_pre_data", 64'(ser_data), 64'(rom_word(8'h00)));
      @(posedge clk);
      #2 RST_n = 1'b0;
      #1;
      check("mr_data", 64'(ser_data), 64'd0);
      check("mr_ovr", 64'(overrun), 64'd0);
      check("mr_tick", 64'(ser_tick), 64'd0);
      ticks = 0;
      repeat (3) begin
         @(negedge clk);
         if (ser_tick) ticks++;
      end
      check("mr_no_tick", 64'(ticks), 64'd0);
      ser_busy = 1'b0;
      RST_n = 1'b1;
      wait_tick(0, cyc, ok);
      check("mr_restart_seen", 64'(ok), 64'd1);
      check("mr_restart_gap", 64'(cyc), 64'd7);
      check("mr_restart_addr", 64'(rom_addr), 64'd0);
      wait_tick(0, cyc, ok);
      check("mr_second_seen", 64'(ok), 64'd1);
      check("mr_second_addr", 64'(rom_addr), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
